// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and helpers for the load/store unit
package load_store_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic [1:0] WM_NONE = 2'd0;
   localparam logic [1:0] WM_BYTE = 2'd1;
   localparam logic [1:0] WM_HALF = 2'd2;
   localparam logic [1:0] WM_WORD = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_WAIT,
      STORE_ACTIVE,
      STORE_RELEASE,
      RESP
   } lsu_state_t;

   // Size 3 is reported as a fault together with the misaligned cases.
   function automatic logic access_fault(input logic [1:0] size, input logic [1:0] addr_lsb);
      logic f;
      case (size)
         SIZE_BYTE: f = 1'b0;
         SIZE_HALF: f = addr_lsb[0];
         SIZE_WORD: f = (addr_lsb != 2'b00);
         default:   f = 1'b1;
      endcase
      return f;
   endfunction

   function automatic logic [1:0] write_mode_for(input logic [1:0] size);
      logic [1:0] wm;
      case (size)
         SIZE_BYTE: wm = WM_BYTE;
         SIZE_HALF: wm = WM_HALF;
         SIZE_WORD: wm = WM_WORD;
         default:   wm = WM_NONE;
      endcase
      return wm;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - lane select with sign/zero extension of load data
module load_extend
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        sign_extend,
   input  logic [7:0]  byte_lane,
   input  logic [15:0] half_lane,
   input  logic [31:0] word_lane,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (size)
         SIZE_BYTE: result = {{24{sign_extend & byte_lane[7]}}, byte_lane};
         SIZE_HALF: result = {{16{sign_extend & half_lane[15]}}, half_lane};
         SIZE_WORD: result = word_lane;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sequences core load/store requests onto the data-memory port
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int READ_LATENCY  = 2,
   parameter int STORE_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_address,
   output logic [1:0]  mem_write_mode,
   output logic [7:0]  mem_write_byte,
   output logic [15:0] mem_write_half_word,
   output logic [31:0] mem_write_word,
   input  logic        mem_done,
   input  logic        mem_error,
   input  logic [7:0]  mem_byte,
   input  logic [15:0] mem_half_word,
   input  logic [31:0] mem_word
);

   localparam logic [7:0] LOAD_LAST  = 8'(READ_LATENCY);
   localparam logic [7:0] STORE_LAST = 8'(STORE_TIMEOUT - 1);

   lsu_state_t  state;
   logic [7:0]  count;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        fault_q;
   logic [31:0] load_result;

   load_extend u_load_extend (
      .size        (size_q),
      .sign_extend (sign_q),
      .byte_lane   (mem_byte),
      .half_lane   (mem_half_word),
      .word_lane   (mem_word),
      .result      (load_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         count               <= '0;
         size_q              <= SIZE_BYTE;
         sign_q              <= 1'b0;
         fault_q             <= 1'b0;
         req_ready           <= 1'b1;
         resp_valid          <= 1'b0;
         resp_rdata          <= '0;
         resp_fault          <= 1'b0;
         mem_address         <= '0;
         mem_write_mode      <= WM_NONE;
         mem_write_byte      <= '0;
         mem_write_half_word <= '0;
         mem_write_word      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready   <= 1'b0;
                  mem_address <= req_address;
                  size_q      <= req_size;
                  sign_q      <= req_signed;
                  count       <= '0;
                  fault_q     <= 1'b0;
                  if (access_fault(req_size, req_address[1:0])) begin
                     // Rejected accesses never touch memory.
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= '0;
                     state      <= RESP;
                  end else if (req_store) begin
                     mem_write_mode      <= write_mode_for(req_size);
                     mem_write_byte      <= req_wdata[7:0];
                     mem_write_half_word <= req_wdata[15:0];
                     mem_write_word      <= req_wdata;
                     state               <= STORE_ACTIVE;
                  end else begin
                     state <= LOAD_WAIT;
                  end
               end
            end
            LOAD_WAIT: begin
               if (count == LOAD_LAST) begin
                  resp_rdata <= load_result;
                  resp_fault <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  count <= count + 8'd1;
               end
            end
            STORE_ACTIVE: begin
               // mem_done takes priority over a timeout landing in the same cycle.
               if (mem_done || count == STORE_LAST) begin
                  fault_q             <= mem_done ? mem_error : 1'b1;
                  mem_write_mode      <= WM_NONE;
                  mem_write_byte      <= '0;
                  mem_write_half_word <= '0;
                  mem_write_word      <= '0;
                  count               <= '0;
                  state               <= STORE_RELEASE;
               end else begin
                  count <= count + 8'd1;
               end
            end
            STORE_RELEASE: begin
               resp_valid <= 1'b1;
               resp_rdata <= '0;
               resp_fault <= fault_q;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid  <= 1'b0;
                  resp_rdata  <= '0;
                  resp_fault  <= 1'b0;
                  req_ready   <= 1'b1;
                  mem_address <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int RL = 2;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_store, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_address, req_wdata;
   logic        resp_valid, resp_ready, resp_fault;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic [1:0]  mem_write_mode;
   logic [7:0]  mem_write_byte;
   logic [15:0] mem_write_half_word;
   logic [31:0] mem_write_word;
   logic        mem_done, mem_error;
   logic [7:0]  mem_byte;
   logic [15:0] mem_half_word;
   logic [31:0] mem_word;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   load_store_unit #(.READ_LATENCY(RL), .STORE_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault),
      .mem_address(mem_address), .mem_write_mode(mem_write_mode),
      .mem_write_byte(mem_write_byte), .mem_write_half_word(mem_write_half_word),
      .mem_write_word(mem_write_word),
      .mem_done(mem_done), .mem_error(mem_error),
      .mem_byte(mem_byte), .mem_half_word(mem_half_word), .mem_word(mem_word)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one outstanding transaction described by event times.
   bit          m_busy = 1'b0;
   bit          m_load, m_store;
   int          m_acc, m_resp_at, m_store_end;
   logic [1:0]  m_size;
   logic        m_sign, m_fault;
   logic [31:0] m_addr, m_wdata, m_rdata;

   function automatic bit bad_access(input logic [1:0] sz, input logic [31:0] addr);
      return (sz == 2'd3) || (sz == 2'd1 && addr[0] != 1'b0) || (sz == 2'd2 && addr[1:0] != 2'd0);
   endfunction

   function automatic logic [31:0] model_extend(input logic [1:0] sz, input logic sg,
                                                input logic [7:0] b, input logic [15:0] h,
                                                input logic [31:0] w);
      int s;
      if (sz == 2'd0) begin
         if (sg) s = $signed(b); else s = int'(b);
         return s;
      end
      if (sz == 2'd1) begin
         if (sg) s = $signed(h); else s = int'(h);
         return s;
      end
      return w;
   endfunction

   task automatic monitor();
      logic       exp_valid;
      logic [1:0] exp_wm;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_write_mode", 32'(mem_write_mode), 32'd0);
            chk("rst_mem_address", mem_address, 32'd0);
            chk("rst_resp_rdata", resp_rdata, 32'd0);
            m_busy = 1'b0;
         end else begin
            exp_valid = m_busy && m_resp_at >= 0 && cyc >= m_resp_at;
            exp_wm = (m_busy && m_store && cyc >= m_acc && cyc < m_store_end) ? m_size + 2'd1 : 2'd0;
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
            chk("write_mode", 32'(mem_write_mode), 32'(exp_wm));
            chk("mem_address", mem_address, m_busy ? m_addr : 32'd0);
            if (exp_valid) begin
               chk("resp_rdata", resp_rdata, m_rdata);
               chk("resp_fault", 32'(resp_fault), 32'(m_fault));
            end
            if (exp_wm != 2'd0) begin
               chk("lane_byte", 32'(mem_write_byte), 32'(m_wdata[7:0]));
               chk("lane_half", 32'(mem_write_half_word), 32'(m_wdata[15:0]));
               chk("lane_word", mem_write_word, m_wdata);
            end
            if (!m_busy) begin
               if (req_valid) begin
                  m_busy  = 1'b1;
                  m_acc   = cyc + 1;
                  m_size  = req_size;
                  m_sign  = req_signed;
                  m_addr  = req_address;
                  m_wdata = req_wdata;
                  m_rdata = 32'd0;
                  m_load  = 1'b0;
                  m_store = 1'b0;
                  if (bad_access(req_size, req_address)) begin
                     m_fault   = 1'b1;
                     m_resp_at = m_acc;
                  end else if (req_store) begin
                     m_store     = 1'b1;
                     m_fault     = 1'b0;
                     m_resp_at   = -1;
                     m_store_end = m_acc + 100000;
                  end else begin
                     m_load    = 1'b1;
                     m_fault   = 1'b0;
                     m_resp_at = m_acc + RL + 1;
                  end
               end
            end else begin
               if (m_load && cyc + 1 == m_resp_at)
                  m_rdata = model_extend(m_size, m_sign, mem_byte, mem_half_word, mem_word);
               if (m_store && m_resp_at < 0 && (mem_done || cyc + 1 == m_acc + TO)) begin
                  m_fault     = mem_done ? mem_error : 1'b1;
                  m_store_end = cyc + 1;
                  m_resp_at   = cyc + 2;
               end
               if (exp_valid && resp_ready) m_busy = 1'b0;
            end
         end
      end
   endtask

   task automatic garbage();
      mem_byte      = 8'h5A;
      mem_half_word = 16'h5A5A;
      mem_word      = 32'h5A5A5A5A;
   endtask

   task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, output int acc);
      logic took;
      req_store = st; req_size = sz; req_signed = sg; req_address = addr; req_wdata = wd;
      req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 64 && acc < 0; i++) begin
         @(negedge clk); took = req_ready;
         @(posedge clk); #1;
         if (took) acc = cyc;
      end
      req_valid = 1'b0;
      chk("accepted", 32'(acc >= 0), 32'd1);
   endtask

   task automatic finish_resp(input int acc, input int exp_lat, input logic [31:0] exp_rd,
                              input logic exp_f, input string tag);
      int lat = -1;
      for (int i = 0; i < 80 && lat < 0; i++) begin
         @(negedge clk);
         if (resp_valid) lat = cyc - acc;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_fault"}, 32'(resp_fault), 32'(exp_f));
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic do_load(input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd, input string tag);
      int acc;
      issue(1'b0, sz, sg, addr, 32'd0, acc);
      repeat (RL) @(posedge clk);
      #1;
      mem_byte = data[7:0]; mem_half_word = data[15:0]; mem_word = data;
      @(posedge clk); #1;
      garbage();
      finish_resp(acc, RL + 1, exp_rd, 1'b0, tag);
   endtask

   task automatic do_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                           input int done_after, input logic err, input int exp_lat,
                           input logic exp_f, input string tag);
      int acc;
      issue(1'b1, sz, 1'b0, addr, wd, acc);
      chk({tag, "_wm"}, 32'(mem_write_mode), 32'(sz) + 32'd1);
      if (done_after > 0) begin
         repeat (done_after - 1) begin @(posedge clk); #1; end
         mem_done = 1'b1; mem_error = err;
         @(posedge clk); #1;
         mem_done = 1'b0; mem_error = 1'b0;
      end
      finish_resp(acc, exp_lat, 32'd0, exp_f, tag);
   endtask

   initial begin
      int acc;
      rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
      req_address = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      mem_done = 1'b0; mem_error = 1'b0;
      garbage();
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_store(SIZE_WORD, 32'h3000, 32'hDEADBEEF, 3, 1'b0, 4, 1'b0, "sw");
      do_load(SIZE_BYTE, 1'b1, 32'h3001, 32'h00000080, 32'hFFFFFF80, "lb_s");
      do_load(SIZE_BYTE, 1'b0, 32'h3001, 32'h00000080, 32'h00000080, "lb_u");
      do_load(SIZE_HALF, 1'b1, 32'h3002, 32'h00008001, 32'hFFFF8001, "lh_s");
      do_load(SIZE_HALF, 1'b0, 32'h3002, 32'h00008001, 32'h00008001, "lh_u");
      do_load(SIZE_WORD, 1'b1, 32'h3004, 32'h87654321, 32'h87654321, "lw");

      issue(1'b0, SIZE_HALF, 1'b1, 32'h3003, 32'd0, acc);
      finish_resp(acc, 0, 32'd0, 1'b1, "lh_misaligned");
      issue(1'b0, 2'd3, 1'b0, 32'h3000, 32'd0, acc);
      finish_resp(acc, 0, 32'd0, 1'b1, "size3");
      issue(1'b1, SIZE_WORD, 1'b0, 32'h3002, 32'hFFFFFFFF, acc);
      chk("sw_misaligned_wm", 32'(mem_write_mode), 32'd0);
      finish_resp(acc, 0, 32'd0, 1'b1, "sw_misaligned");

      do_store(SIZE_BYTE, 32'h3008, 32'h00000012, 2, 1'b1, 3, 1'b1, "sb_error");
      do_store(SIZE_WORD, 32'h300C, 32'hCAFEF00D, 0, 1'b0, TO + 1, 1'b1, "sw_timeout");
      do_store(SIZE_HALF, 32'h3010, 32'h0000BEEF, TO, 1'b0, TO + 1, 1'b0, "sh_done_at_limit");

      // Response back-pressure with a second request waiting.
      issue(1'b0, SIZE_WORD, 1'b0, 32'h3014, 32'd0, acc);
      repeat (RL) @(posedge clk);
      #1;
      mem_word = 32'h0BADF00D;
      @(posedge clk); #1;
      garbage();
      for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
      chk("bp_first_valid", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
      req_store = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0; req_address = 32'h3002;
      req_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_rdata_stable", resp_rdata, 32'h0BADF00D);
         chk("bp_req_ready_low", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("bp_idle_after_handshake", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      acc = cyc;
      chk("bp_second_accepted", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      finish_resp(acc, 0, 32'd0, 1'b1, "bp_second");

      // Reset while a store is in flight.
      issue(1'b1, SIZE_WORD, 1'b0, 32'h3020, 32'h55AA55AA, acc);
      repeat (3) begin @(posedge clk); #1; end
      chk("pre_reset_wm", 32'(mem_write_mode), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_wm", 32'(mem_write_mode), 32'd0);
      chk("mid_reset_req_ready", 32'(req_ready), 32'd1);
      chk("mid_reset_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_store(SIZE_BYTE, 32'h3005, 32'h000000AB, 1, 1'b0, 2, 1'b0, "sb_after_reset");

      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
